// File: rtl/mby_egr_mc_table_arb_if.sv
// Egress requester <-> MC shared-table arbiter bundle.
// master = arbiter side (drives grants, responses and table request); slave = environment.
interface mby_egr_mc_table_arb_if #(
  parameter int N_REQ     = 4,
  parameter int MAX_OUTST = 8
);
  localparam int CW = $clog2(MAX_OUTST + 1);

  logic [N_REQ-1:0] cli_req;
  logic [N_REQ-1:0] cli_gnt;
  logic [N_REQ-1:0] cli_rsp;
  logic             tbl_req;
  logic             tbl_ack;
  logic             tbl_rsp;
  logic [CW-1:0]    outst_cnt;
  logic             err_unexp;
  logic             idle;

  modport master (
    input  cli_req, tbl_ack, tbl_rsp,
    output cli_gnt, cli_rsp, tbl_req, outst_cnt, err_unexp, idle
  );

  modport slave (
    output cli_req, tbl_ack, tbl_rsp,
    input  cli_gnt, cli_rsp, tbl_req, outst_cnt, err_unexp, idle
  );
endinterface

// File: rtl/mby_egr_mc_table_arb.sv
// Round-robin share of the MC table request port; cli_req -> tbl_req in 1 cycle, one request per 2 cycles.
// tbl_req is held until tbl_ack; new issues stall while MAX_OUTST responses are outstanding.
module mby_egr_mc_table_arb #(
  parameter int N_REQ     = 4,
  parameter int MAX_OUTST = 8
) (
  input  logic                   cclk,
  input  logic                   rst_n,
  mby_egr_mc_table_arb_if.master bus
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW  = IDW + 1;
  localparam int AW  = $clog2(MAX_OUTST);
  localparam int PW  = AW + 1;
  localparam int CW  = $clog2(MAX_OUTST + 1);
  localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   win_q, win_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [IDW-1:0]   pick;
  logic             tbl_req_q, tbl_req_d;
  logic [N_REQ-1:0] cli_rsp_q, cli_rsp_d;
  logic [N_REQ-1:0] cli_gnt;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [IDW-1:0]   fifo_q [MAX_OUTST];
  logic [IDW-1:0]   fifo_d [MAX_OUTST];
  logic             push, pop, full, empty;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // Scan downward so the candidate closest to rr_q is assigned last and wins.
  always_comb begin : rr_pick
    logic [SW-1:0] idx;
    pick = rr_q;
    idx  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = {1'b0, rr_q} + SW'(i);
      if (idx >= SW'(N_REQ)) idx = idx - SW'(N_REQ);
      if (bus.cli_req[idx[IDW-1:0]]) pick = idx[IDW-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    rr_d      = rr_q;
    tbl_req_d = tbl_req_q;
    push      = 1'b0;
    cli_gnt   = '0;
    case (state_q)
      ST_IDLE: begin
        if ((|bus.cli_req) && !full) begin
          win_d     = pick;
          tbl_req_d = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.tbl_ack) begin
          push          = 1'b1;
          cli_gnt[win_q] = 1'b1;
          rr_d          = (win_q == LAST_ID) ? '0 : win_q + IDW'(1);
          tbl_req_d     = 1'b0;
          state_d       = ST_IDLE;
        end
      end
    endcase
  end

  // Pop reads the pre-push head, so push+pop in one cycle is safe even when full.
  always_comb begin
    fifo_d    = fifo_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cli_rsp_d = '0;
    pop       = bus.tbl_rsp && !empty;
    err_d     = err_q | (bus.tbl_rsp & empty);
    if (push) begin
      fifo_d[wptr_q[AW-1:0]] = win_q;
      wptr_d = wptr_q + PW'(1);
    end
    if (pop) begin
      cli_rsp_d[fifo_q[rptr_q[AW-1:0]]] = 1'b1;
      rptr_d = rptr_q + PW'(1);
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      win_q     <= '0;
      rr_q      <= '0;
      tbl_req_q <= 1'b0;
      cli_rsp_q <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      rr_q      <= rr_d;
      tbl_req_q <= tbl_req_d;
      cli_rsp_q <= cli_rsp_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
    end
  end

  always_ff @(posedge cclk) begin
    fifo_q <= fifo_d;
  end

  assign bus.tbl_req   = tbl_req_q;
  assign bus.cli_gnt   = cli_gnt;
  assign bus.cli_rsp   = cli_rsp_q;
  assign bus.outst_cnt = cnt_q;
  assign bus.err_unexp = err_q;
  assign bus.idle      = ~(|bus.cli_req) && (state_q == ST_IDLE) && (cnt_q == '0);

`ifndef SYNTHESIS
  a_winner_held: assert property (@(posedge cclk) disable iff (!rst_n)
    (state_q == ST_ISSUE) |-> bus.cli_req[win_q]);
`endif
endmodule

// File: tb/tb_mby_egr_mc_table_arb.sv
// Bench for mby_egr_mc_table_arb: directed vector table, corner-case sequences,
// and a randomized run against a queue-based reference model.
module tb_mby_egr_mc_table_arb;
  localparam int N = 4;
  localparam int M = 8;

  logic cclk = 1'b0;
  logic rst_n;
  always #5 cclk = ~cclk;

  mby_egr_mc_table_arb_if #(.N_REQ(N), .MAX_OUTST(M)) bus ();
  mby_egr_mc_table_arb #(.N_REQ(N), .MAX_OUTST(M)) dut (
    .cclk  (cclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] req;
    logic       ack;
    logic       rsp;
    logic       e_tbl;
    logic [3:0] e_gnt;
    logic [3:0] e_rsp;
    logic [3:0] e_cnt;
    logic       e_idle;
  } vec_t;
  vec_t vec [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic addv(input logic [3:0] r, input logic a, input logic s, input logic t,
                      input logic [3:0] g, input logic [3:0] p, input logic [3:0] c, input logic i);
    vec_t v;
    v.req = r; v.ack = a; v.rsp = s; v.e_tbl = t;
    v.e_gnt = g; v.e_rsp = p; v.e_cnt = c; v.e_idle = i;
    vec.push_back(v);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit before the falling edge.
  task automatic drive(input logic [3:0] r, input logic a, input logic s);
    @(posedge cclk);
    #1;
    bus.cli_req = r;
    bus.tbl_ack = a;
    bus.tbl_rsp = s;
    #3;
  endtask

  task automatic do_reset();
    @(negedge cclk);
    rst_n = 1'b0;
    bus.cli_req = '0;
    bus.tbl_ack = 1'b0;
    bus.tbl_rsp = 1'b0;
    @(negedge cclk);
    @(negedge cclk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         cnt_g;
    int         order [7];
    logic [3:0] req;
    logic       ack, rsp;
    logic [3:0] e_gnt, m_rsp;
    logic       m_busy, m_err;
    int         m_rr, m_win, sz0;
    int         mq [$];

    order = '{2, 3, 0, 1, 2, 3, 0};

    // Round-robin with continuous acks, drain in grant order, then backpressure on requester 2.
    for (int k = 0; k < 5; k++) begin
      addv(4'hF, 1, 0, 0, 4'h0, 4'h0, 4'(2 * k), 0);
      addv(4'hF, 1, 0, 1, 4'(1 << (k % 4)), 4'h0, 4'(2 * k), 0);
    end
    vec.delete(2); vec.delete(2);
    vec.insert(2, '{4'hF, 1, 0, 0, 4'h0, 4'h0, 4'd1, 0});
    vec.insert(3, '{4'hF, 1, 0, 1, 4'h2, 4'h0, 4'd1, 0});
    for (int k = 4; k < 10; k += 2) begin
      vec[k].e_cnt   = 4'(k / 2);
      vec[k+1].e_cnt = 4'(k / 2);
    end
    addv(4'h0, 0, 1, 0, 4'h0, 4'h0, 4'd5, 0);
    addv(4'h0, 0, 1, 0, 4'h0, 4'h1, 4'd4, 0);
    addv(4'h0, 0, 1, 0, 4'h0, 4'h2, 4'd3, 0);
    addv(4'h0, 0, 1, 0, 4'h0, 4'h4, 4'd2, 0);
    addv(4'h0, 0, 1, 0, 4'h0, 4'h8, 4'd1, 0);
    addv(4'h0, 0, 0, 0, 4'h0, 4'h1, 4'd0, 1);
    addv(4'h0, 0, 0, 0, 4'h0, 4'h0, 4'd0, 1);
    addv(4'h4, 0, 0, 0, 4'h0, 4'h0, 4'd0, 0);
    for (int k = 0; k < 5; k++) addv(4'h4, 0, 0, 1, 4'h0, 4'h0, 4'd0, 0);
    addv(4'h4, 1, 0, 1, 4'h4, 4'h0, 4'd0, 0);
    addv(4'h0, 0, 1, 0, 4'h0, 4'h0, 4'd1, 0);
    addv(4'h0, 0, 0, 0, 4'h0, 4'h4, 4'd0, 1);

    rst_n = 1'b0;
    bus.cli_req = '0;
    bus.tbl_ack = 1'b0;
    bus.tbl_rsp = 1'b0;
    repeat (3) @(posedge cclk);
    #1;
    chk("reset tbl_req", bus.tbl_req, 0);
    chk("reset cli_gnt", bus.cli_gnt, 0);
    chk("reset cli_rsp", bus.cli_rsp, 0);
    chk("reset outst_cnt", bus.outst_cnt, 0);
    chk("reset err_unexp", bus.err_unexp, 0);
    chk("reset idle", bus.idle, 1);
    @(negedge cclk);
    rst_n = 1'b1;

    foreach (vec[i]) begin
      drive(vec[i].req, vec[i].ack, vec[i].rsp);
      chk($sformatf("vec%0d tbl_req", i), bus.tbl_req, vec[i].e_tbl);
      chk($sformatf("vec%0d cli_gnt", i), bus.cli_gnt, vec[i].e_gnt);
      chk($sformatf("vec%0d cli_rsp", i), bus.cli_rsp, vec[i].e_rsp);
      chk($sformatf("vec%0d outst_cnt", i), bus.outst_cnt, vec[i].e_cnt);
      chk($sformatf("vec%0d idle", i), bus.idle, vec[i].e_idle);
    end

    // Fill to MAX_OUTST, confirm the stall, then release one slot and overlap ack with rsp.
    do_reset();
    cnt_g = 0;
    for (int c = 0; c < 40 && cnt_g < 8; c++) begin
      drive(4'hF, 1, 0);
      if (bus.cli_gnt != 0) begin
        chk($sformatf("full gnt%0d", cnt_g), bus.cli_gnt, 1 << (cnt_g % 4));
        cnt_g++;
      end
    end
    chk("full grant count", cnt_g, 8);
    repeat (3) begin
      drive(4'hF, 1, 0);
      chk("full tbl_req", bus.tbl_req, 0);
      chk("full outst_cnt", bus.outst_cnt, 8);
    end
    drive(4'hF, 0, 1);
    chk("full pop tbl_req", bus.tbl_req, 0);
    chk("full pop outst_cnt", bus.outst_cnt, 8);
    drive(4'hF, 0, 0);
    chk("full pop cli_rsp", bus.cli_rsp, 4'h1);
    chk("full pop cnt7", bus.outst_cnt, 7);
    chk("full pop no issue", bus.tbl_req, 0);
    drive(4'hF, 1, 1);
    chk("simul tbl_req", bus.tbl_req, 1);
    chk("simul cli_gnt", bus.cli_gnt, 4'h1);
    chk("simul outst_cnt", bus.outst_cnt, 7);
    for (int i = 0; i < 8; i++) begin
      drive(4'h0, 0, (i < 7));
      chk($sformatf("drain%0d cli_rsp", i), bus.cli_rsp, (i == 0) ? 4'h2 : 4'(1 << order[i-1]));
      chk($sformatf("drain%0d outst_cnt", i), bus.outst_cnt, 7 - i);
    end
    chk("drain err_unexp", bus.err_unexp, 0);

    // Response with nothing outstanding.
    drive(4'h0, 0, 1);
    chk("unexp pre err", bus.err_unexp, 0);
    chk("unexp pre cnt", bus.outst_cnt, 0);
    drive(4'h0, 0, 0);
    chk("unexp cli_rsp", bus.cli_rsp, 0);
    chk("unexp err", bus.err_unexp, 1);
    repeat (3) drive(4'h0, 0, 0);
    chk("unexp sticky", bus.err_unexp, 1);
    chk("unexp idle", bus.idle, 1);

    // Reset in the middle of an ISSUE with one response outstanding.
    drive(4'h4, 0, 0);
    drive(4'h4, 1, 0);
    chk("rst pre gnt", bus.cli_gnt, 4'h4);
    drive(4'h4, 0, 0);
    drive(4'h4, 0, 0);
    chk("rst pre tbl_req", bus.tbl_req, 1);
    chk("rst pre cnt", bus.outst_cnt, 1);
    #1;
    rst_n = 1'b0;
    bus.cli_req = '0;
    #1;
    chk("rst mid tbl_req", bus.tbl_req, 0);
    chk("rst mid cnt", bus.outst_cnt, 0);
    chk("rst mid idle", bus.idle, 1);
    chk("rst mid err", bus.err_unexp, 0);
    chk("rst mid cli_rsp", bus.cli_rsp, 0);
    @(negedge cclk);
    rst_n = 1'b1;
    drive(4'h0, 0, 1);
    chk("rst lost err pre", bus.err_unexp, 0);
    drive(4'h0, 0, 0);
    chk("rst lost err", bus.err_unexp, 1);
    chk("rst lost cli_rsp", bus.cli_rsp, 0);

    // Randomized traffic against the reference model.
    do_reset();
    req = '0;
    m_busy = 1'b0; m_err = 1'b0; m_rr = 0; m_win = 0; m_rsp = '0;
    mq.delete();
    for (int c = 0; c < 3000; c++) begin
      ack = ($urandom_range(0, 2) != 0);
      rsp = (mq.size() > 0) && ($urandom_range(0, 99) < ((c < 1500) ? 20 : 60));
      drive(req, ack, rsp);
      e_gnt = (m_busy && ack) ? 4'(1 << m_win) : 4'h0;
      chk("rnd tbl_req", bus.tbl_req, m_busy);
      chk("rnd cli_gnt", bus.cli_gnt, e_gnt);
      chk("rnd cli_rsp", bus.cli_rsp, m_rsp);
      chk("rnd outst_cnt", bus.outst_cnt, mq.size());
      chk("rnd err_unexp", bus.err_unexp, m_err);
      chk("rnd idle", bus.idle, (req == 0) && !m_busy && (mq.size() == 0));
      sz0 = mq.size();
      m_rsp = '0;
      if (rsp) begin
        if (sz0 == 0) m_err = 1'b1;
        else begin
          m_rsp = 4'(1 << mq[0]);
          void'(mq.pop_front());
        end
      end
      if (m_busy) begin
        if (ack) begin
          mq.push_back(m_win);
          m_rr   = (m_win + 1) % N;
          m_busy = 1'b0;
        end
      end else if (req != 0 && sz0 < M) begin
        for (int k = N - 1; k >= 0; k--)
          if (req[(m_rr + k) % N]) m_win = (m_rr + k) % N;
        m_busy = 1'b1;
      end
      req = (req & ~e_gnt) | 4'($urandom_range(0, 15) & $urandom_range(0, 15));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
